// File: rtl/output_stream_buffer.sv
// rtl/output_stream_buffer.sv - first-word-fall-through FIFO between the MAC controller and the output consumer
module output_stream_buffer #(
   parameter int ACCUMULATION_WIDTH = 32,
   parameter int FIFO_DEPTH         = 8,
   parameter int FEATURE_MAP_WIDTH  = 1024,
   parameter int FEATURE_MAP_HEIGHT = 1024,
   parameter int OUTPUT_NB_CHANNELS = 64
) (
   input  logic                            clk,
   input  logic                            arst_n_in,
   input  logic                            start,
   input  logic                            in_valid,
   input  logic [ACCUMULATION_WIDTH-1:0]   in_data,
   input  logic [31:0]                     in_x,
   input  logic [31:0]                     in_y,
   input  logic [31:0]                     in_ch,
   input  logic                            out_ready,
   output logic                            out_valid,
   output logic [ACCUMULATION_WIDTH-1:0]   out_data,
   output logic [31:0]                     out_x,
   output logic [31:0]                     out_y,
   output logic [31:0]                     out_ch,
   output logic                            almost_full,
   output logic [$clog2(FIFO_DEPTH):0]     occupancy,
   output logic                            overflow,
   output logic                            done
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int EW = ACCUMULATION_WIDTH + 96;
   localparam logic [PW:0] DEPTH_L = (PW+1)'(FIFO_DEPTH);
   localparam logic [31:0] TOTAL = 32'(FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS);

   logic [EW-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_addr;
   logic [31:0]   delivered;
   logic          full;
   logic          pop_req;
   logic          push;
   logic          pop;

   assign full    = (occupancy == DEPTH_L);
   assign pop_req = out_valid & out_ready;
   // start empties the FIFO first, so a word arriving with it always fits
   assign push    = in_valid & (start | ~full | pop_req);
   assign pop     = pop_req & ~start;
   assign wr_addr = start ? '0 : wr_ptr;

   assign out_valid   = (occupancy != '0);
   assign almost_full = (occupancy >= DEPTH_L - (PW+1)'(2));
   assign {out_data, out_x, out_y, out_ch} = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_addr] <= {in_data, in_x, in_y, in_ch};
   end

   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
         delivered <= '0;
         overflow  <= 1'b0;
         done      <= 1'b0;
      end else if (start) begin
         wr_ptr    <= push ? PW'(1) : '0;
         rd_ptr    <= '0;
         occupancy <= (PW+1)'(push);
         delivered <= '0;
         overflow  <= 1'b0;
         done      <= 1'b0;
      end else begin
         wr_ptr    <= wr_ptr + PW'(push);
         rd_ptr    <= rd_ptr + PW'(pop);
         occupancy <= occupancy + (PW+1)'(push) - (PW+1)'(pop);
         if (in_valid && full && !pop_req)
            overflow <= 1'b1;
         // counter saturates at the map total; done latches on the final pop
         if (pop && delivered != TOTAL)
            delivered <= delivered + 32'd1;
         if (pop && delivered == TOTAL - 32'd1)
            done <= 1'b1;
      end
   end

endmodule

// File: tb/tb_output_stream_buffer.sv
// tb/tb_output_stream_buffer.sv - directed vector bench for output_stream_buffer
module tb_output_stream_buffer;

   logic        clk = 1'b0;
   logic        arst_n_in;
   logic        start;
   logic        in_valid;
   logic [31:0] in_data;
   logic [31:0] in_x, in_y, in_ch;
   logic        out_ready;
   logic        out_valid;
   logic [31:0] out_data, out_x, out_y, out_ch;
   logic        almost_full;
   logic [3:0]  occupancy;
   logic        overflow;
   logic        done;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   output_stream_buffer #(
      .ACCUMULATION_WIDTH(32),
      .FIFO_DEPTH(8),
      .FEATURE_MAP_WIDTH(2),
      .FEATURE_MAP_HEIGHT(2),
      .OUTPUT_NB_CHANNELS(2)
   ) dut (
      .clk(clk), .arst_n_in(arst_n_in), .start(start),
      .in_valid(in_valid), .in_data(in_data), .in_x(in_x), .in_y(in_y), .in_ch(in_ch),
      .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
      .out_x(out_x), .out_y(out_y), .out_ch(out_ch),
      .almost_full(almost_full), .occupancy(occupancy), .overflow(overflow), .done(done)
   );

   typedef struct {
      logic        st;
      logic        iv;
      logic [31:0] d;
      logic        rdy;
      logic [3:0]  e_occ;
      logic        e_vld;
      logic [31:0] e_data;
      logic        e_af;
      logic        e_ovf;
      logic        e_done;
   } vec_t;

   vec_t tbl[15];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic st, input logic iv, input logic [31:0] d, input logic rdy);
      start     = st;
      in_valid  = iv;
      in_data   = d;
      in_x      = d + 32'd1;
      in_y      = d + 32'd2;
      in_ch     = d + 32'd3;
      out_ready = rdy;
   endtask

   initial begin
      logic [31:0] exp_head;

      arst_n_in = 1'b0;
      drive(1'b0, 1'b0, 32'd0, 1'b0);
      #2;
      chk("reset_occ", occupancy, 0);
      chk("reset_valid", out_valid, 0);
      chk("reset_af", almost_full, 0);
      chk("reset_ovf", overflow, 0);
      chk("reset_done", done, 0);
      #5 arst_n_in = 1'b1;

      // fill to overflow, partial drain, then start with a simultaneous push
      tbl[0] = '{1'b1, 1'b0, 32'd0, 1'b0, 4'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0};
      for (int k = 1; k <= 8; k++)
         tbl[k] = '{1'b0, 1'b1, 32'(k), 1'b0, 4'(k), 1'b1, 32'd1, (k >= 6), 1'b0, 1'b0};
      tbl[9]  = '{1'b0, 1'b1, 32'd9, 1'b0, 4'd8, 1'b1, 32'd1, 1'b1, 1'b1, 1'b0};
      tbl[10] = '{1'b0, 1'b0, 32'd0, 1'b1, 4'd7, 1'b1, 32'd2, 1'b1, 1'b1, 1'b0};
      tbl[11] = '{1'b0, 1'b0, 32'd0, 1'b1, 4'd6, 1'b1, 32'd3, 1'b1, 1'b1, 1'b0};
      tbl[12] = '{1'b0, 1'b0, 32'd0, 1'b1, 4'd5, 1'b1, 32'd4, 1'b0, 1'b1, 1'b0};
      tbl[13] = '{1'b1, 1'b1, 32'hAA, 1'b1, 4'd1, 1'b1, 32'hAA, 1'b0, 1'b0, 1'b0};
      tbl[14] = '{1'b0, 1'b0, 32'd0, 1'b1, 4'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0};

      for (int i = 0; i < 15; i++) begin
         drive(tbl[i].st, tbl[i].iv, tbl[i].d, tbl[i].rdy);
         tick();
         chk($sformatf("v%0d_occ", i), occupancy, tbl[i].e_occ);
         chk($sformatf("v%0d_valid", i), out_valid, tbl[i].e_vld);
         chk($sformatf("v%0d_af", i), almost_full, tbl[i].e_af);
         chk($sformatf("v%0d_ovf", i), overflow, tbl[i].e_ovf);
         chk($sformatf("v%0d_done", i), done, tbl[i].e_done);
         if (tbl[i].e_vld) begin
            chk($sformatf("v%0d_data", i), out_data, tbl[i].e_data);
            chk($sformatf("v%0d_x", i), out_x, tbl[i].e_data + 32'd1);
         end
      end

      // single push held against a stalled consumer
      drive(1'b1, 1'b0, 32'd0, 1'b0);
      tick();
      start = 1'b0; in_valid = 1'b1; in_data = 32'h11;
      in_x = 32'd1; in_y = 32'd2; in_ch = 32'd3;
      tick();
      in_valid = 1'b0;
      for (int c = 0; c < 5; c++) begin
         chk("hold_valid", out_valid, 1);
         chk("hold_data", out_data, 32'h11);
         chk("hold_xyz", {out_x[15:0], out_y[15:0], out_ch[15:0]}, {16'd1, 16'd2, 16'd3});
         chk("hold_occ", occupancy, 1);
         tick();
      end

      // full FIFO with concurrent push/pop across pointer wrap
      drive(1'b1, 1'b0, 32'd0, 1'b0);
      tick();
      for (int k = 1; k <= 8; k++) begin
         drive(1'b0, 1'b1, 32'(k), 1'b0);
         tick();
      end
      exp_head = 32'd1;
      for (int c = 0; c < 20; c++) begin
         drive(1'b0, 1'b1, 32'(9 + c), 1'b1);
         chk("wrap_head", out_data, exp_head);
         exp_head++;
         tick();
         chk("wrap_occ", occupancy, 8);
         chk("wrap_ovf", overflow, 0);
      end
      drive(1'b0, 1'b0, 32'd0, 1'b1);
      for (int c = 0; c < 8; c++) begin
         chk("drain_head", out_data, exp_head);
         exp_head++;
         tick();
      end
      chk("drain_occ", occupancy, 0);

      // done after the 8th delivered word of a 2x2x2 map
      drive(1'b1, 1'b0, 32'd0, 1'b0);
      tick();
      chk("done_cleared", done, 0);
      for (int k = 1; k <= 8; k++) begin
         drive(1'b0, 1'b1, 32'(100 + k), 1'b1);
         tick();
      end
      chk("done_before_last", done, 0);
      drive(1'b0, 1'b0, 32'd0, 1'b1);
      tick();
      chk("done_set", done, 1);
      chk("done_occ", occupancy, 0);
      for (int c = 0; c < 2; c++) begin
         drive(1'b0, 1'b1, 32'(200 + c), 1'b1);
         tick();
         drive(1'b0, 1'b0, 32'd0, 1'b1);
         tick();
         chk("done_held", done, 1);
      end

      // asynchronous reset between edges
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 1'b1, 32'(50 + k), 1'b0);
         tick();
      end
      in_valid = 1'b0;
      chk("pre_reset_occ", occupancy, 3);
      #2 arst_n_in = 1'b0;
      #1;
      chk("async_valid", out_valid, 0);
      chk("async_occ", occupancy, 0);
      chk("async_done", done, 0);
      #2 arst_n_in = 1'b1;
      drive(1'b0, 1'b1, 32'h55, 1'b0);
      tick();
      in_valid = 1'b0;
      chk("post_reset_data", out_data, 32'h55);
      chk("post_reset_occ", occupancy, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
